fa_serie: RTL and testbench
===========================

FA_SERIE -- requirements
Module: fa_serie

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand and result width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising clk.
REQ-005 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 SHALL have port a  input  N  first operand; sampled with start.
REQ-007 SHALL have port b  input  N  second operand; sampled with start.
REQ-008 SHALL have port sum  output  N  registered result.
REQ-009 SHALL have port c_out  output  1  final carry out (for subtract, 1 = no borrow).
REQ-010 SHALL have port ovf  output  1  two's-complement overflow of the result.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking a valid result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE or DONE with start=1 at a rising edge, latch a, b and op into internal shift registers, initialise the carry flip-flop to op, clear the bit counter and enter RUN.
REQ-015 SHALL, in RUN, process one bit per cycle LSB first through a single 1-bit full adder: s = a_i ^ (b_i ^ op) ^ c; c_next = majority(a_i, b_i ^ op, c).
REQ-016 SHALL shift each result bit into the sum register from the MSB end, so sum holds the full N-bit result after N RUN cycles.
REQ-017 SHALL leave RUN for DONE on the edge that processes bit N-1; this gives exactly N RUN cycles.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, first visible at edge N after the start-capturing edge; DONE returns to IDLE the next edge unless start=1.
REQ-019 SHALL assert busy exactly while in RUN.
REQ-020 SHALL set c_out to the carry out of bit N-1 and ovf to (carry into bit N-1) XOR (carry out of bit N-1), both registered on entry to DONE.
REQ-021 SHALL hold sum, c_out and ovf stable from DONE until the next accepted start; intermediate sum bits MAY be visible during RUN.
REQ-022 SHALL ignore start while in RUN; no relatch, no restart, no effect on the result.
REQ-023 SHALL accept start in the DONE cycle, giving back-to-back operations with no IDLE cycle.
REQ-024 SHALL ignore changes to a, b and op except on the start-capturing edge.
REQ-025 SHALL wrap results modulo 2^N; overflow is reported only through c_out/ovf.

Reset
REQ-026 SHALL, on reset=1 and without waiting for clk, force state IDLE and sum=0, c_out=0, ovf=0, busy=0, done=0, counter=0, carry=0.
REQ-027 SHALL, on reset asserted mid-RUN, abort the operation, produce no done pulse, and wait in IDLE for a new start after release.
REQ-028 SHALL ignore start while reset=1.

Verification
REQ-029 SHALL test: N=8, op=0, a=0x5A, b=0x3C, start pulse -> busy 8 cycles, done at edge 8, sum=0x96, c_out=0, ovf=1.
REQ-030 SHALL test: op=0, a=0xFF, b=0x01 -> sum=0x00, c_out=1, ovf=0.
REQ-031 SHALL test: op=1, a=0x10, b=0x20 -> sum=0xF0, c_out=0, ovf=0; then op=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.
REQ-032 SHALL test: start held high with operands changed on cycles 2-5 of RUN -> result matches the originally latched operands, single done pulse; start high in DONE cycle -> second operation begins with no IDLE cycle.
REQ-033 SHALL test: reset asserted at cycle 4 of RUN, between clock edges -> outputs 0 immediately, no done; new start after release -> correct result.
REQ-034 SHALL test: exhaustive check with N=4, all a, b, op against a reference model of sum, c_out and ovf.

Source files
------------

// File: rtl/fa_serie.sv
// Bit-serial adder/subtractor: one full adder processes operands LSB first, one bit per clock.
// Latency: N clocks from the start-capturing edge to the done pulse; busy is high for exactly those N cycles.
// Backpressure: none; start is ignored while busy and accepted in IDLE or in the DONE cycle (back-to-back).
module fa_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic           op_r;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last_bit;
  logic           b_eff;
  logic           s_bit;
  logic           c_next;

  // A new operation is taken only outside RUN; reset priority is handled by the async clear.
  assign accept   = (state != RUN) && start;
  assign last_bit = (cnt == CW'(N - 1));

  // The single full adder; subtract inverts b and seeds the carry with 1.
  assign b_eff  = b_sh[0] ^ op_r;
  assign s_bit  = a_sh[0] ^ b_eff ^ carry;
  assign c_next = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN lasts exactly N cycles, DONE lasts one unless restarted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add with result shifted in from the MSB end, flags on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      op_r  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      op_r  <= op;
      carry <= op;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_next;
      cnt   <= cnt + 1'b1;
      sum   <= {s_bit, sum[N-1:1]};
      if (last_bit) begin
        c_out <= c_next;
        // carry holds the carry into bit N-1 at this point
        ovf   <= carry ^ c_next;
      end
    end
  end

endmodule

// File: tb/tb_fa_serie.sv
// Self-checking bench for fa_serie: directed 8-bit vectors plus an exhaustive 4-bit sweep.
// Latency expectations: busy for N cycles, done visible N edges after the capturing edge.
// Drives inputs and samples outputs 1 time unit after the rising edge.
module tb_fa_serie;

  logic       clk;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       c_out;
  logic       ovf;
  logic       busy;
  logic       done;

  logic       reset4;
  logic       start4;
  logic       op4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic [3:0] sum4;
  logic       c_out4;
  logic       ovf4;
  logic       busy4;
  logic       done4;

  int checks = 0;
  int errors = 0;

  fa_serie #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done)
  );

  fa_serie #(.N(4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .op(op4), .a(a4), .b(b4),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Capture an 8-bit operation on the next edge; leaves start low afterwards.
  task automatic start8(input logic o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, counting edges since capture and cycles spent busy.
  task automatic wait8(output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op8(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] es, input logic ec, input logic eo);
    int cyc, bcnt;
    start8(o, x, y);
    wait8(cyc, bcnt);
    check({tag, "_done_edge"}, cyc, 8);
    check({tag, "_busy_cycles"}, bcnt, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_c_out"}, c_out, ec);
    check({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc, bcnt, dones;
    logic [4:0] s5;
    logic [3:0] bb;
    logic       eo;

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    reset4 = 1'b1; start4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    check("rst_sum", sum, 0);
    check("rst_flags", {c_out, ovf, busy, done}, 0);
    check("rst4_all", {sum4, c_out4, ovf4, busy4, done4}, 0);
    #10;
    reset = 1'b0; reset4 = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    op8("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start held high, operands disturbed mid-RUN, then back-to-back restart from DONE
    op = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i >= 2 && i <= 5) begin
        a = 8'($urandom); b = 8'($urandom); op = ~op;
      end
      if (i == 8) begin
        op = 1'b1; a = 8'h50; b = 8'h20;
      end
      @(posedge clk); #1;
      if (i < 8) dones += int'(done);
    end
    check("hold_no_early_done", dones, 0);
    check("hold_done", done, 1);
    check("hold_sum", sum, 8'h46);
    check("hold_flags", {c_out, ovf}, 2'b00);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_no_done", done, 0);
    wait8(cyc, bcnt);
    check("b2b_done_edge", cyc, 8);
    check("b2b_sum", sum, 8'h30);
    check("b2b_flags", {c_out, ovf}, 2'b10);
    @(posedge clk); #1;

    // Reset between edges at RUN cycle 4
    start8(1'b0, 8'h5A, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b1; start = 1'b1;
    #1;
    check("mid_rst_sum", sum, 0);
    check("mid_rst_flags", {c_out, ovf, busy, done}, 0);
    @(posedge clk); #1;
    check("rst_ignores_start", busy, 0);
    start = 1'b0;
    #2;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      dones += int'(done) + int'(busy);
    end
    check("post_rst_quiet", dones, 0);
    op8("post_rst_add", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

    // Exhaustive 4-bit sweep against an arithmetic reference
    for (int o = 0; o < 2; o++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          bb = (o == 1) ? ~4'(y) : 4'(y);
          s5 = 5'(x) + 5'(bb) + 5'(o);
          eo = (x[3] == bb[3]) && (s5[3] != x[3]);
          op4 = o[0]; a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          cyc = 0;
          while (!done4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
          end
          if (cyc != 4) check("ex4_done_edge", cyc, 4);
          if ({sum4, c_out4, ovf4} !== {s5[3:0], s5[4], eo})
            check($sformatf("ex4_op%0d_a%0h_b%0h", o, x, y), {sum4, c_out4, ovf4}, {s5[3:0], s5[4], eo});
          else
            checks++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
